pipelined_cla_adder: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor; successor to the fixed 64-bit registered adder. Operands are registered, then split into `STAGES` equal chunks, with one chunk resolved per pipeline stage and the carry forwarded stage-to-stage. A valid/ready handshake with global stall makes it drop-in for streaming datapaths such as accumulator and ALU blocks. Optional signed-overflow detection is compiled in by macro.

---
 rtl/pipelined_cla_adder.sv | 118 +++++++++++
 tb/tb_pipelined_cla_adder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one CHUNK-wide lookahead slice per stage, valid/ready with global stall.
// Optional signed-overflow output is enabled by defining PCLA_OVERFLOW_EN.
module pipelined_cla_adder #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] q,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow
);

  localparam int unsigned CHUNK = WIDTH / STAGES;

  // Kogge-Stone prefix over one chunk; returns {carry_out, sum}.
  function automatic logic [CHUNK:0] cla_chunk(input logic [CHUNK-1:0] a,
                                               input logic [CHUNK-1:0] b,
                                               input logic             ci);
    logic [CHUNK-1:0] g;
    logic [CHUNK-1:0] t;
    logic [CHUNK-1:0] gg;
    logic [CHUNK-1:0] pp;
    logic [CHUNK:0]   c;
    g  = a & b;
    t  = a ^ b;
    gg = g;
    pp = t;
    for (int d = 1; d < int'(CHUNK); d = d * 2) begin
      for (int i = int'(CHUNK) - 1; i >= d; i--) begin
        gg[i] = gg[i] | (pp[i] & gg[i-d]);
        pp[i] = pp[i] & pp[i-d];
      end
    end
    c[0] = ci;
    for (int i = 0; i < int'(CHUNK); i++) begin
      c[i+1] = gg[i] | (pp[i] & ci);
    end
    return {c[CHUNK], t ^ c[CHUNK-1:0]};
  endfunction

  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES+1];
  logic [STAGES:0]  c_q;
  logic [STAGES:0]  v_q;
  logic [CHUNK:0]   chunk_res [STAGES];
  logic             stall;

  assign stall    = v_q[STAGES] & ~out_ready;
  assign in_ready = ~stall;

  // Stage k resolves chunk k-1 from the operands and carry held in stage k-1.
  for (genvar k = 1; k <= int'(STAGES); k++) begin : g_chunk
    assign chunk_res[k-1] = cla_chunk(a_q[k-1][(k-1)*CHUNK +: CHUNK],
                                      b_q[k-1][(k-1)*CHUNK +: CHUNK],
                                      c_q[k-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q         <= '0;
      s_q[STAGES] <= '0;
      c_q[STAGES] <= 1'b0;
    end else if (!stall) begin
      v_q    <= {v_q[STAGES-1:0], in_valid};
      a_q[0] <= p;
      b_q[0] <= sub ? ~q : q;
      c_q[0] <= sub | cin;
      s_q[0] <= '0;
      for (int k = 1; k <= int'(STAGES); k++) begin
        s_q[k]                       <= s_q[k-1];
        s_q[k][(k-1)*CHUNK +: CHUNK] <= chunk_res[k-1][CHUNK-1:0];
        c_q[k]                       <= chunk_res[k-1][CHUNK];
      end
      for (int k = 1; k < int'(STAGES); k++) begin
        a_q[k] <= a_q[k-1];
        b_q[k] <= b_q[k-1];
      end
    end
  end

  assign out_valid = v_q[STAGES];
  assign result    = s_q[STAGES];
  assign carry     = c_q[STAGES];

`ifdef PCLA_OVERFLOW_EN
  // Operand sign bits stay untouched in the forwarded operands until the last chunk.
  logic ovf_q;
  logic sign_a;
  logic sign_b;
  logic sign_r;
  assign sign_a = a_q[STAGES-1][WIDTH-1];
  assign sign_b = b_q[STAGES-1][WIDTH-1];
  assign sign_r = chunk_res[STAGES-1][CHUNK-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (!stall) begin
      ovf_q <= (sign_a == sign_b) & (sign_r != sign_a);
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder: 64/4 main instance plus 32/1 and 16/16 sweep instances.
module tb_pipelined_cla_adder;

  localparam int unsigned W = 64;
  localparam int unsigned S = 4;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         o;
    int           acc;
    bit           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] p = '0;
  logic [W-1:0] q = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         carry;
  logic         overflow;

  logic [31:0] p32 = '0, q32 = '0, r32;
  logic        v32 = 1'b0, rdy32, ov32, c32, o32;
  logic [15:0] p16 = '0, q16 = '0, r16;
  logic        v16 = 1'b0, rdy16, ov16, c16, o16;
  logic        cin_s = 1'b0, sub_s = 1'b0;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   lat_chk = 1'b0;
  bit   rnd_ready = 1'b0;
  exp_t exp_q[$];

  pipelined_cla_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .p(p), .q(q),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .overflow(overflow));

  pipelined_cla_adder #(.WIDTH(32), .STAGES(1)) dut32 (
    .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdy32), .p(p32), .q(q32),
    .cin(cin_s), .sub(sub_s), .out_valid(ov32), .out_ready(1'b1),
    .result(r32), .carry(c32), .overflow(o32));

  pipelined_cla_adder #(.WIDTH(16), .STAGES(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16), .p(p16), .q(q16),
    .cin(cin_s), .sub(sub_s), .out_valid(ov16), .out_ready(1'b1),
    .result(r16), .carry(c16), .overflow(o16));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  end

  // Reference: plain wide arithmetic; returns {overflow, carry, result}.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic ci, input logic sb);
    logic [W-1:0] be;
    logic [W:0]   sum;
    logic         ov;
    be  = sb ? ~b : b;
    sum = {1'b0, a} + {1'b0, be} + (W+1)'(sb | ci);
    ov  = 1'b0;
`ifdef PCLA_OVERFLOW_EN
    ov  = (a[W-1] == be[W-1]) && (sum[W-1] != a[W-1]);
`endif
    return {ov, sum};
  endfunction

  // Monitor: in_ready rule, stall stability, scoreboard push/pop.
  logic [W-1:0] prev_res;
  logic         prev_c, prev_o, prev_v;
  bit           stall_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      checks++;
      assert (in_ready === ~(out_valid & ~out_ready)) else begin
        errors++;
        $error("FAIL in_ready observed=%b expected=%b", in_ready, ~(out_valid & ~out_ready));
      end
      if (stall_prev) begin
        checks++;
        assert ({out_valid, result, carry, overflow} === {prev_v, prev_res, prev_c, prev_o}) else begin
          errors++;
          $error("FAIL stall_hold observed=%b/%h/%b/%b expected=%b/%h/%b/%b", out_valid, result,
                 carry, overflow, prev_v, prev_res, prev_c, prev_o);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL stray_beat observed=%h expected=no beat", result);
          end
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          assert ({result, carry, overflow} === {e.res, e.c, e.o}) else begin
            errors++;
            $error("FAIL result observed=%h/c%b/o%b expected=%h/c%b/o%b", result, carry, overflow,
                   e.res, e.c, e.o);
          end
          if (e.lat) begin
            checks++;
            assert (cyc - e.acc === int'(S) + 1) else begin
              errors++;
              $error("FAIL latency observed=%0d expected=%0d", cyc - e.acc, S + 1);
            end
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_t e;
        logic [W+1:0] m;
        m     = model(p, q, cin, sub);
        e.res = m[W-1:0];
        e.c   = m[W];
        e.o   = m[W+1];
        e.acc = cyc;
        e.lat = lat_chk;
        exp_q.push_back(e);
      end
      prev_res   = result;
      prev_c     = carry;
      prev_o     = overflow;
      prev_v     = out_valid;
      stall_prev = out_valid & ~out_ready;
    end
  end

  task automatic drive_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic ci, input logic sb);
    bit ok;
    p = a; q = b; cin = ci; sub = sb; in_valid = 1'b1;
    for (int g = 0; g < 200; g++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) begin
        in_valid = 1'b0;
        return;
      end
    end
    errors++;
    $display("FAIL accept_timeout observed=in_ready low expected=accept within 200 cycles");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "accept timeout");
  endtask

  task automatic drain();
    for (int g = 0; g < 300; g++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL drain observed=%0d pending expected=0", exp_q.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic [32:0]  e32;
    logic [16:0]  e16;
    int           k32, k16;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    assert ({out_valid, result, carry, overflow, in_ready} === {1'b0, {W{1'b0}}, 1'b0, 1'b0, 1'b1})
    else begin
      errors++;
      $error("FAIL reset_state observed=%b/%h/%b/%b/%b expected=0/0/0/0/1", out_valid, result,
             carry, overflow, in_ready);
    end

    // Directed: full ripple add, subtract both ways, signed overflow.
    lat_chk = 1'b1;
    drive_beat(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    drain();
    drive_beat(64'd5, 64'd7, 1'b1, 1'b1);
    drive_beat(64'd7, 64'd5, 1'b0, 1'b1);
    drive_beat(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    drive_beat(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1);
    drive_beat(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0);
    drain();

    // Streaming with random backpressure.
    lat_chk   = 1'b0;
    rnd_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      drive_beat(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain();
    rnd_ready = 1'b0;
    out_ready = 1'b1;

    // Reset with beats in flight.
    drive_beat(64'd1, 64'd2, 1'b0, 1'b0);
    drive_beat(64'd3, 64'd4, 1'b0, 1'b0);
    drive_beat(64'd5, 64'd6, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    assert ({out_valid, in_ready} === 2'b01) else begin
      errors++;
      $error("FAIL mid_reset observed=valid%b ready%b expected=valid0 ready1", out_valid, in_ready);
    end
    repeat (8) @(posedge clk);
    #1;
    lat_chk = 1'b1;
    drive_beat(64'd100, 64'd23, 1'b0, 1'b0);
    drain();

    // Parameter sweep instances, no backpressure.
    for (int i = 0; i < 8; i++) begin
      p32 = $urandom; q32 = $urandom;
      p16 = 16'($urandom); q16 = 16'($urandom);
      cin_s = 1'($urandom_range(0, 1));
      sub_s = 1'($urandom_range(0, 1));
      e32 = {1'b0, p32} + {1'b0, (sub_s ? ~q32 : q32)} + 33'(sub_s | cin_s);
      e16 = {1'b0, p16} + {1'b0, (sub_s ? ~q16 : q16)} + 17'(sub_s | cin_s);
      v32 = 1'b1; v16 = 1'b1;
      k32 = 0; k16 = 0;
      for (int k = 1; k <= 20; k++) begin
        @(posedge clk);
        #1;
        v32 = 1'b0; v16 = 1'b0;
        if (ov32 && k32 == 0) begin
          k32 = k;
          checks++;
          assert ({c32, r32} === e32) else begin
            errors++;
            $error("FAIL sum32 observed=%h expected=%h", {c32, r32}, e32);
          end
        end
        if (ov16 && k16 == 0) begin
          k16 = k;
          checks++;
          assert ({c16, r16} === e16) else begin
            errors++;
            $error("FAIL sum16 observed=%h expected=%h", {c16, r16}, e16);
          end
        end
      end
      checks++;
      assert (k32 == 2 && k16 == 17) else begin
        errors++;
        $error("FAIL sweep_latency observed=%0d/%0d expected=2/17", k32, k16);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
